// File: rtl/rot_left_pipe_if.sv
// Handshake bundle for rot_left_pipe: operand/amount/carry in with valid/ready,
// rotated result and carry out with valid/ready.
interface rot_left_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inp_data;
  logic [4:0]  amount;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        carry_out;

  modport master (
    output in_valid, inp_data, amount, carry_in, out_ready,
    input  in_ready, out_valid, out_data, carry_out
  );

  modport slave (
    input  in_valid, inp_data, amount, carry_in, out_ready,
    output in_ready, out_valid, out_data, carry_out
  );
endinterface

// File: rtl/rot_left_pipe.sv
// Five-stage rotate-left unit: stage k applies a rotate by 2^k when amount bit k is set.
// The whole pipe freezes while a result is pending at the output and not accepted.
module rot_left_pipe (
  input  logic             clk,
  input  logic             rst,
  rot_left_pipe_if.slave   bus
);
  localparam int unsigned NSTG = 5;

  logic        r_vld  [NSTG];
  logic [31:0] r_data [NSTG];
  logic [4:0]  r_amt  [NSTG-1];
  logic        r_cin  [NSTG];
  logic        r_nz   [NSTG];

  logic        w_stall;
  logic        w_src_vld  [NSTG];
  logic [31:0] w_src_data [NSTG];
  logic [4:0]  w_src_amt  [NSTG];
  logic        w_src_cin  [NSTG];
  logic        w_src_nz   [NSTG];
  logic [31:0] w_nxt_data [NSTG];

  function automatic logic [31:0] rotl(input logic [31:0] d, input int unsigned n);
    logic [63:0] t;
    t = {d, d} << n;
    return t[63:32];
  endfunction

  assign w_stall       = r_vld[NSTG-1] && !bus.out_ready;
  assign bus.in_ready  = !w_stall;
  assign bus.out_valid = r_vld[NSTG-1];
  assign bus.out_data  = r_data[NSTG-1];
  assign bus.carry_out = r_nz[NSTG-1] ? r_data[NSTG-1][0] : r_cin[NSTG-1];

  // Amount is shifted down one bit per stage, so every stage consumes bit 0.
  always_comb begin
    w_src_vld[0]  = bus.in_valid;
    w_src_data[0] = bus.inp_data;
    w_src_amt[0]  = bus.amount;
    w_src_cin[0]  = bus.carry_in;
    w_src_nz[0]   = (bus.amount != '0);
    for (int unsigned k = 1; k < NSTG; k++) begin
      w_src_vld[k]  = r_vld[k-1];
      w_src_data[k] = r_data[k-1];
      w_src_amt[k]  = r_amt[k-1];
      w_src_cin[k]  = r_cin[k-1];
      w_src_nz[k]   = r_nz[k-1];
    end
    for (int unsigned k = 0; k < NSTG; k++) begin
      w_nxt_data[k] = w_src_amt[k][0] ? rotl(w_src_data[k], 32'd1 << k) : w_src_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        r_vld[k]  <= 1'b0;
        r_data[k] <= '0;
        r_cin[k]  <= 1'b0;
        r_nz[k]   <= 1'b0;
      end
      for (int unsigned k = 0; k < NSTG-1; k++) begin
        r_amt[k] <= '0;
      end
    end else if (!w_stall) begin
      for (int unsigned k = 0; k < NSTG; k++) begin
        r_vld[k]  <= w_src_vld[k];
        r_data[k] <= w_nxt_data[k];
        r_cin[k]  <= w_src_cin[k];
        r_nz[k]   <= w_src_nz[k];
      end
      for (int unsigned k = 0; k < NSTG-1; k++) begin
        r_amt[k] <= w_src_amt[k] >> 1;
      end
    end
  end
endmodule

// File: tb/tb_rot_left_pipe.sv
// Scoreboard bench for rot_left_pipe: the driver queues hand-computed results on
// acceptance, a negedge monitor pops and compares on every output transfer.
module tb_rot_left_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rot_left_pipe_if bus ();
  rot_left_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;
  logic [32:0] sb_q [$];
  logic [32:0] mon_exp;
  logic        mon_prev_stall = 1'b0;
  logic [31:0] mon_prev_data;
  logic        mon_prev_cy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: output transfers, hold stability and in_ready during stalls
  always @(negedge clk) begin
    if (rst) begin
      mon_prev_stall = 1'b0;
    end else begin
      if (mon_prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", bus.out_data, mon_prev_data);
        chk("hold_carry", 32'(bus.carry_out), 32'(mon_prev_cy));
      end
      if (bus.out_valid && !bus.out_ready) chk("in_ready_stall", 32'(bus.in_ready), 32'd0);
      else                                 chk("in_ready_free", 32'(bus.in_ready), 32'd1);
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: got %h expected no result", bus.out_data);
        end else begin
          mon_exp = sb_q.pop_front();
          chk("out_data", bus.out_data, mon_exp[31:0]);
          chk("carry_out", 32'(bus.carry_out), 32'(mon_exp[32]));
          n_xfer++;
        end
      end
      mon_prev_stall = bus.out_valid && !bus.out_ready;
      mon_prev_data  = bus.out_data;
      mon_prev_cy    = bus.carry_out;
    end
  end

  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic c,
                      input logic [31:0] ed, input logic ec);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.inp_data = d;
    bus.amount   = a;
    bus.carry_in = c;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end else begin
      sb_q.push_back({ec, ed});
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", sb_q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.inp_data  = '0;
    bus.amount    = '0;
    bus.carry_in  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_data", bus.out_data, 32'h0);
    chk("rst_carry", 32'(bus.carry_out), 32'd0);
    @(posedge clk); #1;

    // Basic rotate with latency measurement
    send(32'h8000_0001, 5'd1, 1'b0, 32'h0000_0003, 1'b1);
    n = 1;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 32'd5);
    @(posedge clk); #1;

    send(32'h1234_5678, 5'd16, 1'b1, 32'h5678_1234, 1'b0);
    send(32'h1234_5678, 5'd4,  1'b0, 32'h2345_6781, 1'b1);
    send(32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000, 1'b0);
    send(32'hDEAD_BEEF, 5'd0,  1'b1, 32'hDEAD_BEEF, 1'b1);
    send(32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 1'b0);
    send(32'hC000_0000, 5'd2,  1'b0, 32'h0000_0003, 1'b1);
    send(32'hA5A5_A5A5, 5'd8,  1'b0, 32'hA5A5_A5A5, 1'b1);
    drain();

    // Streaming with a 3-cycle output stall after the second result
    n_xfer = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(32'h1, 5'(i), 1'b1, 32'h1 << i, (i == 0));
      end
      begin
        t = 0;
        while (n_xfer < 2 && t < 200) begin
          @(posedge clk);
          t++;
        end
        if (t >= 200) begin
          n_checks++;
          $display("FAIL stall_wait: transfers got %0d expected 2", n_xfer);
        end
        #1 bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
          chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_out_data", bus.out_data, 32'h4);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_count", n_xfer, 32'd8);

    // Bubbles: alternating in_valid reappears 5 cycles later
    for (int j = 0; j < 13; j++) begin
      bus.in_valid = (j < 8) && (j % 2 == 0);
      bus.inp_data = 32'h8000_0000;
      bus.amount   = 5'd1;
      bus.carry_in = 1'b0;
      @(negedge clk);
      if (bus.in_valid) begin
        chk("bubble_in_ready", 32'(bus.in_ready), 32'd1);
        sb_q.push_back({1'b1, 32'h0000_0001});
      end
      if (j >= 5)
        chk("bubble_pattern", 32'(bus.out_valid), 32'(((j - 5) < 8) && ((j - 5) % 2 == 0)));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain();

    // Reset mid-flight discards three accepted operations
    for (int j = 0; j < 3; j++) begin
      bus.in_valid = 1'b1;
      bus.inp_data = 32'hF0F0_0000 | 32'(j);
      bus.amount   = 5'(j + 3);
      bus.carry_in = 1'b1;
      @(negedge clk);
      chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_pre_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_out_data", bus.out_data, 32'h0);
    chk("mid_carry", 32'(bus.carry_out), 32'd0);
    chk("mid_in_ready_after", 32'(bus.in_ready), 32'd1);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("mid_no_output", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;

    send(32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000, 1'b0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
